// File: rtl/filter_ctrl_axil_slave.sv
// AXI4-Lite register block for the camera filter pipeline: CTRL, PARAM0..2, read-only STATUS.
// Optional FILTER_CTRL_SHADOW_EN: outputs come from shadow copies loaded by a CTRL[31] commit.
module filter_ctrl_axil_slave #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 5,
  parameter int STATUS_W             = 8
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     ctrl_o,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     param0_o,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     param1_o,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     param2_o,
  input  logic [STATUS_W-1:0]                 status_i,
  output logic                                cfg_update_o
);

  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int AW = C_S00_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic          ready_en_reg;
  logic          aw_held_reg;
  logic [AW-1:0] aw_addr_reg;
  logic          w_held_reg;
  logic [DW-1:0] w_data_reg;
  logic [SW-1:0] w_strb_reg;
  logic          bvalid_reg;
  logic [1:0]    bresp_reg;
  logic          rvalid_reg;
  logic [1:0]    rresp_reg;
  logic [DW-1:0] rdata_reg;
  logic          cfg_update_reg;
  logic [DW-1:0] regs_reg [4];

  // READYs stay low until the first edge after reset release.
  assign s00_axi_awready = ready_en_reg & ~aw_held_reg & ~bvalid_reg;
  assign s00_axi_wready  = ready_en_reg & ~w_held_reg & ~bvalid_reg;
  assign s00_axi_arready = ready_en_reg & ~rvalid_reg;
  assign s00_axi_bvalid  = bvalid_reg;
  assign s00_axi_bresp   = bresp_reg;
  assign s00_axi_rvalid  = rvalid_reg;
  assign s00_axi_rresp   = rresp_reg;
  assign s00_axi_rdata   = rdata_reg;
  assign cfg_update_o    = cfg_update_reg;

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = s00_axi_awvalid & s00_axi_awready;
  assign w_hs  = s00_axi_wvalid & s00_axi_wready;
  assign ar_hs = s00_axi_arvalid & s00_axi_arready;

  // A handshake on this edge counts as held, so the commit needs no extra cycle.
  logic          wr_commit, wr_ok, cfg_fire;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic [2:0]    wr_idx;
  assign wr_addr   = aw_held_reg ? aw_addr_reg : s00_axi_awaddr;
  assign wr_data   = w_held_reg ? w_data_reg : s00_axi_wdata;
  assign wr_strb   = w_held_reg ? w_strb_reg : s00_axi_wstrb;
  assign wr_commit = (aw_held_reg | aw_hs) & (w_held_reg | w_hs);
  assign wr_idx    = wr_addr[4:2];
  assign wr_ok     = ~wr_idx[2];

  logic [DW-1:0] cur_word, merged_word, wr_word;
  assign cur_word = regs_reg[wr_idx[1:0]];
  for (genvar gi = 0; gi < SW; gi++) begin : g_lane
    assign merged_word[8*gi +: 8] = wr_strb[gi] ? wr_data[8*gi +: 8] : cur_word[8*gi +: 8];
  end

  logic [DW-1:0] status_ext;
  always_comb begin
    status_ext                 = '0;
    status_ext[STATUS_W-1:0]   = status_i;
  end

  logic [2:0]    rd_idx;
  logic [DW-1:0] rd_word;
  logic [1:0]    rd_resp;
  assign rd_idx = s00_axi_araddr[4:2];
  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    if (!rd_idx[2])
      rd_word = regs_reg[rd_idx[1:0]];
    else if (rd_idx == 3'd4)
      rd_word = status_ext;
    else
      rd_resp = RESP_SLVERR;
  end

`ifdef FILTER_CTRL_SHADOW_EN
  // CTRL[31] is a trigger, never stored.
  assign wr_word  = (wr_idx == 3'd0) ? {1'b0, merged_word[DW-2:0]} : merged_word;
  assign cfg_fire = wr_ok & (wr_idx == 3'd0) & wr_data[DW-1] & wr_strb[SW-1];

  logic [DW-1:0] shadow_reg [4];
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) shadow_reg[i] <= '0;
    end else if (wr_commit && cfg_fire) begin
      shadow_reg[0] <= wr_word;
      shadow_reg[1] <= regs_reg[1];
      shadow_reg[2] <= regs_reg[2];
      shadow_reg[3] <= regs_reg[3];
    end
  end
  assign ctrl_o   = shadow_reg[0];
  assign param0_o = shadow_reg[1];
  assign param1_o = shadow_reg[2];
  assign param2_o = shadow_reg[3];
`else
  assign wr_word  = merged_word;
  assign cfg_fire = wr_ok;
  assign ctrl_o   = regs_reg[0];
  assign param0_o = regs_reg[1];
  assign param1_o = regs_reg[2];
  assign param2_o = regs_reg[3];
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en_reg   <= 1'b0;
      aw_held_reg    <= 1'b0;
      aw_addr_reg    <= '0;
      w_held_reg     <= 1'b0;
      w_data_reg     <= '0;
      w_strb_reg     <= '0;
      bvalid_reg     <= 1'b0;
      bresp_reg      <= RESP_OKAY;
      rvalid_reg     <= 1'b0;
      rresp_reg      <= RESP_OKAY;
      rdata_reg      <= '0;
      cfg_update_reg <= 1'b0;
      for (int i = 0; i < 4; i++) regs_reg[i] <= '0;
    end else begin
      ready_en_reg   <= 1'b1;
      cfg_update_reg <= 1'b0;

      if (wr_commit) begin
        aw_held_reg    <= 1'b0;
        w_held_reg     <= 1'b0;
        bvalid_reg     <= 1'b1;
        bresp_reg      <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        cfg_update_reg <= cfg_fire;
        if (wr_ok) regs_reg[wr_idx[1:0]] <= wr_word;
      end else begin
        if (aw_hs) begin
          aw_held_reg <= 1'b1;
          aw_addr_reg <= s00_axi_awaddr;
        end
        if (w_hs) begin
          w_held_reg <= 1'b1;
          w_data_reg <= s00_axi_wdata;
          w_strb_reg <= s00_axi_wstrb;
        end
      end
      if (bvalid_reg && s00_axi_bready) bvalid_reg <= 1'b0;

      // Registers update on this same edge, so a colliding read sees the old value.
      if (ar_hs) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_word;
        rresp_reg  <= rd_resp;
      end else if (rvalid_reg && s00_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, wr_addr[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_filter_ctrl_axil_slave.sv
// Directed bench for filter_ctrl_axil_slave: queued expected B/R responses checked by monitors,
// plus direct checks of outputs, handshake timing and reset behaviour.
module tb_filter_ctrl_axil_slave;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [4:0]  s00_axi_awaddr = '0;
  logic [2:0]  s00_axi_awprot = '0;
  logic        s00_axi_awvalid = 1'b0;
  logic        s00_axi_awready;
  logic [31:0] s00_axi_wdata = '0;
  logic [3:0]  s00_axi_wstrb = '0;
  logic        s00_axi_wvalid = 1'b0;
  logic        s00_axi_wready;
  logic [1:0]  s00_axi_bresp;
  logic        s00_axi_bvalid;
  logic        s00_axi_bready = 1'b1;
  logic [4:0]  s00_axi_araddr = '0;
  logic [2:0]  s00_axi_arprot = '0;
  logic        s00_axi_arvalid = 1'b0;
  logic        s00_axi_arready;
  logic [31:0] s00_axi_rdata;
  logic [1:0]  s00_axi_rresp;
  logic        s00_axi_rvalid;
  logic        s00_axi_rready = 1'b1;
  logic [31:0] ctrl_o, param0_o, param1_o, param2_o;
  logic [7:0]  status_i = '0;
  logic        cfg_update_o;

  filter_ctrl_axil_slave #(
    .C_S00_AXI_DATA_WIDTH(32),
    .C_S00_AXI_ADDR_WIDTH(5),
    .STATUS_W(8)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s00_axi_awaddr(s00_axi_awaddr), .s00_axi_awprot(s00_axi_awprot),
    .s00_axi_awvalid(s00_axi_awvalid), .s00_axi_awready(s00_axi_awready),
    .s00_axi_wdata(s00_axi_wdata), .s00_axi_wstrb(s00_axi_wstrb),
    .s00_axi_wvalid(s00_axi_wvalid), .s00_axi_wready(s00_axi_wready),
    .s00_axi_bresp(s00_axi_bresp), .s00_axi_bvalid(s00_axi_bvalid),
    .s00_axi_bready(s00_axi_bready),
    .s00_axi_araddr(s00_axi_araddr), .s00_axi_arprot(s00_axi_arprot),
    .s00_axi_arvalid(s00_axi_arvalid), .s00_axi_arready(s00_axi_arready),
    .s00_axi_rdata(s00_axi_rdata), .s00_axi_rresp(s00_axi_rresp),
    .s00_axi_rvalid(s00_axi_rvalid), .s00_axi_rready(s00_axi_rready),
    .ctrl_o(ctrl_o), .param0_o(param0_o), .param1_o(param1_o), .param2_o(param2_o),
    .status_i(status_i), .cfg_update_o(cfg_update_o)
  );

  always #5 ACLK = ~ACLK;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cfg_cnt = 0;
  logic [1:0]  exp_bresp[$];
  logic [31:0] exp_rdata[$];
  logic [1:0]  exp_rresp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
  endtask

  always @(negedge ACLK) if (cfg_update_o) cfg_cnt++;

  // Write-response monitor
  always @(negedge ACLK) begin
    if (ARESETN && s00_axi_bvalid && s00_axi_bready) begin
      if (exp_bresp.size() == 0) begin
        total_cnt++;
        $display("FAIL b_unexpected: got bresp %0d, expected no response", s00_axi_bresp);
      end else begin
        logic [1:0] eb;
        eb = exp_bresp.pop_front();
        $display("B  bresp=%0d", s00_axi_bresp);
        check("bresp", 32'(s00_axi_bresp), 32'(eb));
      end
    end
  end

  // Read-response monitor
  always @(negedge ACLK) begin
    if (ARESETN && s00_axi_rvalid && s00_axi_rready) begin
      if (exp_rdata.size() == 0) begin
        total_cnt++;
        $display("FAIL r_unexpected: got rdata 0x%08h, expected no response", s00_axi_rdata);
      end else begin
        logic [31:0] ed;
        logic [1:0]  er;
        ed = exp_rdata.pop_front();
        er = exp_rresp.pop_front();
        $display("R  rdata=0x%08h rresp=%0d", s00_axi_rdata, s00_axi_rresp);
        check("rdata", s00_axi_rdata, ed);
        check("rresp", 32'(s00_axi_rresp), 32'(er));
      end
    end
  end

  task automatic aw_send(input logic [4:0] a);
    bit ok = 0;
    s00_axi_awaddr  = a;
    s00_axi_awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (s00_axi_awready) begin ok = 1; break; end
    end
    if (!ok) check("awready_timeout", 32'(s00_axi_awready), 32'd1);
    @(posedge ACLK); #1;
    s00_axi_awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    s00_axi_wdata  = d;
    s00_axi_wstrb  = s;
    s00_axi_wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (s00_axi_wready) begin ok = 1; break; end
    end
    if (!ok) check("wready_timeout", 32'(s00_axi_wready), 32'd1);
    @(posedge ACLK); #1;
    s00_axi_wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [4:0] a);
    bit ok = 0;
    s00_axi_araddr  = a;
    s00_axi_arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (s00_axi_arready) begin ok = 1; break; end
    end
    if (!ok) check("arready_timeout", 32'(s00_axi_arready), 32'd1);
    @(posedge ACLK); #1;
    s00_axi_arvalid = 1'b0;
  endtask

  task automatic issue_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er);
    exp_bresp.push_back(er);
    fork
      aw_send(a);
      w_send(d, s);
    join
  endtask

  task automatic issue_read(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er);
    exp_rdata.push_back(ed);
    exp_rresp.push_back(er);
    ar_send(a);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (exp_bresp.size() == 0 && exp_rdata.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      check("drain_timeout", 32'(exp_bresp.size() + exp_rdata.size()), 32'd0);
      exp_bresp.delete(); exp_rdata.delete(); exp_rresp.delete();
    end
    @(posedge ACLK); #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er);
    issue_write(a, d, s, er);
    drain();
  endtask

  task automatic do_read(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er);
    issue_read(a, ed, er);
    drain();
  endtask

  int c0;

  initial begin
    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", 32'(s00_axi_awready), 32'd0);
    check("rst_arready", 32'(s00_axi_arready), 32'd0);
    check("rst_bvalid", 32'(s00_axi_bvalid), 32'd0);
    check("rst_rdata", s00_axi_rdata, 32'd0);
    check("rst_ctrl_o", ctrl_o, 32'd0);
    check("rst_cfg_update", 32'(cfg_update_o), 32'd0);
    #2 ARESETN = 1'b1;
    @(negedge ACLK);
    check("rel_awready", 32'(s00_axi_awready), 32'd1);
    check("rel_arready", 32'(s00_axi_arready), 32'd1);
    @(posedge ACLK); #1;

`ifndef FILTER_CTRL_SHADOW_EN
    // Basic write / readback
    c0 = cfg_cnt;
    do_write(5'h00, 32'h1, 4'hF, OKAY);
    do_write(5'h04, 32'h2, 4'hF, OKAY);
    do_write(5'h08, 32'h3, 4'hF, OKAY);
    do_write(5'h0C, 32'h4, 4'hF, OKAY);
    check("cfg_pulses_4", 32'(cfg_cnt - c0), 32'd4);
    do_read(5'h00, 32'h1, OKAY);
    do_read(5'h04, 32'h2, OKAY);
    do_read(5'h08, 32'h3, OKAY);
    do_read(5'h0C, 32'h4, OKAY);
    check("ctrl_o", ctrl_o, 32'h1);
    check("param0_o", param0_o, 32'h2);
    check("param2_o", param2_o, 32'h4);

    // Byte strobes
    do_write(5'h04, 32'h0, 4'hF, OKAY);
    c0 = cfg_cnt;
    do_write(5'h04, 32'hAABBCCDD, 4'b0101, OKAY);
    check("cfg_pulse_strb", 32'(cfg_cnt - c0), 32'd1);
    do_read(5'h04, 32'h00BB00DD, OKAY);

    // Same-edge read and write of CTRL returns the old value
    fork
      issue_write(5'h00, 32'h9, 4'hF, OKAY);
      issue_read(5'h00, 32'h1, OKAY);
    join
    drain();
    do_read(5'h00, 32'h9, OKAY);

    // W three cycles ahead of AW, with bready held off
    c0 = cfg_cnt;
    s00_axi_bready = 1'b0;
    exp_bresp.push_back(OKAY);
    w_send(32'h1234_5678, 4'hF);
    @(negedge ACLK);
    check("wready_while_held", 32'(s00_axi_wready), 32'd0);
    repeat (2) @(posedge ACLK); #1;
    aw_send(5'h08);
    @(negedge ACLK);
    check("bvalid_latency_w_first", 32'(s00_axi_bvalid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("bvalid_hold", 32'(s00_axi_bvalid), 32'd1);
      check("awready_blocked", 32'(s00_axi_awready), 32'd0);
    end
    @(posedge ACLK); #1;
    s00_axi_bready = 1'b1;
    drain();

    // AW and W in the same cycle
    exp_bresp.push_back(OKAY);
    fork
      aw_send(5'h0C);
      w_send(32'hCAFE_0001, 4'hF);
    join
    @(negedge ACLK);
    check("bvalid_latency_same", 32'(s00_axi_bvalid), 32'd1);
    drain();
    check("cfg_pulses_2", 32'(cfg_cnt - c0), 32'd2);
    do_read(5'h08, 32'h1234_5678, OKAY);
    do_read(5'h0C, 32'hCAFE_0001, OKAY);

    // Unmapped / read-only accesses
    c0 = cfg_cnt;
    status_i = 8'h00;
    do_write(5'h10, 32'hFFFF_FFFF, 4'hF, SLVERR);
    check("cfg_no_pulse_slverr", 32'(cfg_cnt - c0), 32'd0);
    do_write(5'h18, 32'hFFFF_FFFF, 4'hF, SLVERR);
    do_read(5'h10, 32'h0, OKAY);
    do_read(5'h14, 32'h0, SLVERR);
    do_read(5'h1C, 32'h0, SLVERR);
    status_i = 8'h5A;
    do_read(5'h10, 32'h0000_005A, OKAY);
    check("ctrl_after_slverr", ctrl_o, 32'h9);

    // Reset while AW is held and W pending
    s00_axi_awaddr  = 5'h00;
    s00_axi_awvalid = 1'b1;
    @(posedge ACLK); #1;
    s00_axi_awvalid = 1'b0;
    @(negedge ACLK);
    check("aw_held_blocks", 32'(s00_axi_awready), 32'd0);
    #2 ARESETN = 1'b0;
    #1;
    check("async_rst_ctrl", ctrl_o, 32'd0);
    check("async_rst_param0", param0_o, 32'd0);
    check("async_rst_arready", 32'(s00_axi_arready), 32'd0);
    repeat (2) @(posedge ACLK); #1;
    ARESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("no_bvalid_after_rst", 32'(s00_axi_bvalid), 32'd0);
    end
    @(posedge ACLK); #1;
    do_write(5'h0C, 32'h55, 4'hF, OKAY);
    do_read(5'h0C, 32'h55, OKAY);
    do_read(5'h00, 32'h0, OKAY);
    check("param2_after_rst", param2_o, 32'h55);
`else
    // Shadowed outputs only move on a CTRL[31] commit
    c0 = cfg_cnt;
    do_write(5'h04, 32'h7, 4'hF, OKAY);
    check("shadow_param0_held", param0_o, 32'h0);
    check("shadow_no_pulse", 32'(cfg_cnt - c0), 32'd0);
    exp_bresp.push_back(OKAY);
    fork
      aw_send(5'h00);
      w_send(32'h8000_0003, 4'hF);
    join
    check("shadow_param0", param0_o, 32'h7);
    check("shadow_ctrl", ctrl_o, 32'h3);
    check("shadow_cfg_pulse", 32'(cfg_update_o), 32'd1);
    drain();
    check("shadow_pulse_count", 32'(cfg_cnt - c0), 32'd1);
    do_read(5'h00, 32'h3, OKAY);
    do_read(5'h04, 32'h7, OKAY);
`endif

    repeat (3) @(posedge ACLK);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
